sobel_window_ctrl: RTL

Streaming sequencer for the combinational sobel_module. Accepts a raster-order 8-bit pixel stream and keeps two line buffers plus a 3x3 window register. It drives the sobel_module neighbour and threshold inputs and returns one edge bit per interior pixel through a valid/ready handshake. It sits between the pixel source (camera or frame reader) and the edge-map sink.

---
 rtl/sobel_window_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/sobel_window_ctrl.sv
// Raster-stream 3x3 window sequencer feeding a combinational sobel_module.
// Define SOBEL_EDGE_COUNT_EN to add the per-frame edge_count output.
module sobel_window_ctrl #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int COL_W      = 10,
  parameter int ROW_W      = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] thresh_in,
  input  logic       pix_valid,
  input  logic [7:0] pix_data,
  output logic       pix_ready,
  output logic [7:0] p0,
  output logic [7:0] p1,
  output logic [7:0] p2,
  output logic [7:0] p3,
  output logic [7:0] p5,
  output logic [7:0] p6,
  output logic [7:0] p7,
  output logic [7:0] p8,
  output logic [7:0] threshold,
  input  logic       sobel_result,
  output logic       edge_valid,
  output logic       edge_data,
  input  logic       edge_ready,
  output logic       busy,
`ifdef SOBEL_EDGE_COUNT_EN
  output logic [COL_W+ROW_W-1:0] edge_count,
`endif
  output logic       frame_done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state, state_nxt;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic [2:0][2:0][7:0] win;  // [top/mid/bottom][left/mid/right]
  logic [7:0]         lb0 [IMG_WIDTH];
  logic [7:0]         lb1 [IMG_WIDTH];
  logic               accept, hs, col_last, row_last, qual, go;

  assign accept   = pix_valid && pix_ready;
  assign hs       = edge_valid && edge_ready;
  assign go       = (state == IDLE) && start;
  assign col_last = (col == COL_W'(IMG_WIDTH - 1));
  assign row_last = (row == ROW_W'(IMG_HEIGHT - 1));
  assign qual     = accept && (row >= ROW_W'(2)) && (col >= COL_W'(2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (accept && col_last && row_last) state_nxt = DRAIN;
      DRAIN:   if (hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pix_ready = (state == RUN) && (!edge_valid || edge_ready);
    busy      = (state != IDLE);
  end

  // Line buffers hold no reset; contents before row 2 never reach a qualified window.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col] <= lb0[col];
      lb0[col] <= pix_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      win        <= '0;
      threshold  <= '0;
      edge_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= (state == DRAIN) && hs;
      if (go) begin
        threshold <= thresh_in;
        col       <= '0;
        row       <= '0;
      end else if (accept) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end
      if (accept) begin
        for (int i = 0; i < 3; i++) begin
          win[i][0] <= win[i][1];
          win[i][1] <= win[i][2];
        end
        win[0][2] <= lb1[col];
        win[1][2] <= lb0[col];
        win[2][2] <= pix_data;
      end
      // A qualifying accept wins over a same-cycle handshake to keep 1 pixel/cycle.
      if (qual)            edge_valid <= 1'b1;
      else if (edge_ready) edge_valid <= 1'b0;
    end
  end

`ifdef SOBEL_EDGE_COUNT_EN
  logic [COL_W+ROW_W-1:0] ecnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ecnt       <= '0;
      edge_count <= '0;
    end else begin
      if (go)                    ecnt <= '0;
      else if (hs && edge_data)  ecnt <= ecnt + 1'b1;
      if ((state == DRAIN) && hs)
        edge_count <= ecnt + (COL_W+ROW_W)'(edge_data);
    end
  end
`endif

  assign p0 = win[0][0];
  assign p1 = win[0][1];
  assign p2 = win[0][2];
  assign p3 = win[1][0];
  assign p5 = win[1][2];
  assign p6 = win[2][0];
  assign p7 = win[2][1];
  assign p8 = win[2][2];
  assign edge_data = sobel_result;

endmodule
